player_sprite_plotter: RTL

Consumer side of the player position/colour interface: accepts one sprite draw or erase request (origin x, y, colour), then scans the sprite's W×H pixel block out to the VGA adapter's plot port, one pixel per clock. It sits between the player movement control path and the VGA adapter. It replaces ad-hoc pixel counting in the movement FSM with a request/done handshake.

---
 rtl/sprite_pkg.sv | 26 ++
 rtl/player_sprite_plotter_if.sv | 19 +
 rtl/player_sprite_mask.sv | 30 +++
 rtl/player_sprite_plotter.sv | 130 +++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared constants, colours and plotter state type for the player sprite path.
package sprite_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] WHITE = 3'b111;

  localparam logic [6:0] PLAYER_Y  = 7'd99;
  localparam logic [7:0] PLAYER_X0 = 8'd14;
  localparam logic [7:0] PLAYER_X1 = 8'd54;
  localparam logic [7:0] PLAYER_X2 = 8'd94;
  localparam logic [7:0] PLAYER_X3 = 8'd134;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLOT,
    ST_DONE
  } plot_state_t;

  function automatic logic on_screen(input logic [8:0] sx, input logic [7:0] sy);
    return (sx < 9'(SCREEN_W)) && (sy < 8'(SCREEN_H));
  endfunction

endpackage

// File: rtl/player_sprite_plotter_if.sv
// Draw/erase request handshake between the movement control path and the plotter.
interface player_sprite_plotter_if;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_x;
  logic [6:0] req_y;
  logic [2:0] req_colour;
  logic       req_erase;

  modport master (
    output req_valid, req_x, req_y, req_colour, req_erase,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_x, req_y, req_colour, req_erase,
    output req_ready
  );
endinterface

// File: rtl/player_sprite_mask.sv
// Ship-shape lookup: 1 where the sprite cell (cx, cy) is part of the ship.
module player_sprite_mask (
  input  logic [3:0] cx,
  input  logic [3:0] cy,
  output logic       mask
);

  logic [15:0] row;

  // Bit n of a row is column n; the shape is left/right symmetric.
  always_comb begin
    row = '0;
    unique case (cy)
      4'd0:    row = 16'b0000000000110000;
      4'd1:    row = 16'b0000000000110000;
      4'd2:    row = 16'b0000000001111000;
      4'd3:    row = 16'b0000000001111000;
      4'd4:    row = 16'b0000000011111100;
      4'd5:    row = 16'b0000001011111101;
      4'd6:    row = 16'b0000001111111111;
      4'd7:    row = 16'b0000001111111111;
      4'd8:    row = 16'b0000001110110111;
      4'd9:    row = 16'b0000001100000011;
      default: row = '0;
    endcase
  end

  assign mask = row[cx];

endmodule

// File: rtl/player_sprite_plotter.sv
// Scans one SPR_W x SPR_H sprite block out to the VGA plot port per request.
// Optional ship-shape masking when PLAYER_SPRITE_MASK_EN is defined.
module player_sprite_plotter
  import sprite_pkg::*;
#(
  parameter int unsigned SPR_W = 10,
  parameter int unsigned SPR_H = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  player_sprite_plotter_if.slave req,
  output logic [7:0]             vga_x,
  output logic [6:0]             vga_y,
  output logic [2:0]             vga_colour,
  output logic                   vga_plot,
  output logic                   busy,
  output logic                   done
);

  localparam logic [3:0] LAST_X = 4'(SPR_W - 1);
  localparam logic [3:0] LAST_Y = 4'(SPR_H - 1);

  plot_state_t state;
  logic [7:0]  x0;
  logic [6:0]  y0;
  logic [2:0]  col;
  logic [3:0]  cx, cy;

  logic [3:0]  nx, ny;
  logic [7:0]  bx;
  logic [6:0]  by;
  logic [2:0]  bc;
  logic [8:0]  sum_x;
  logic [7:0]  sum_y;
  logic        mask_bit;
  logic        pix_on;

  assign req.req_ready = (state == ST_IDLE) && !reset;
  assign busy          = (state != ST_IDLE);

  // Next pixel to register: in IDLE it is pixel 0 of the incoming request,
  // so the first pixel appears on the cycle right after acceptance.
  always_comb begin
    nx = '0;
    ny = '0;
    bx = x0;
    by = y0;
    bc = col;
    if (state == ST_IDLE) begin
      bx = req.req_x;
      by = req.req_y;
      bc = req.req_erase ? BLACK : req.req_colour;
    end else if (cx == LAST_X) begin
      ny = cy + 4'd1;
    end else begin
      nx = cx + 4'd1;
      ny = cy;
    end
    sum_x  = {1'b0, bx} + {5'b0, nx};
    sum_y  = {1'b0, by} + {4'b0, ny};
    pix_on = on_screen(sum_x, sum_y) && mask_bit;
  end

`ifdef PLAYER_SPRITE_MASK_EN
  player_sprite_mask u_mask (
    .cx   (nx),
    .cy   (ny),
    .mask (mask_bit)
  );
`else
  assign mask_bit = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      x0         <= '0;
      y0         <= '0;
      col        <= '0;
      cx         <= '0;
      cy         <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
      done       <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          done     <= 1'b0;
          vga_plot <= 1'b0;
          if (req.req_valid) begin
            x0         <= bx;
            y0         <= by;
            col        <= bc;
            cx         <= nx;
            cy         <= ny;
            vga_x      <= sum_x[7:0];
            vga_y      <= sum_y[6:0];
            vga_colour <= bc;
            vga_plot   <= pix_on;
            state      <= ST_PLOT;
          end
        end
        ST_PLOT: begin
          if (cx == LAST_X && cy == LAST_Y) begin
            cx       <= '0;
            cy       <= '0;
            vga_plot <= 1'b0;
            done     <= 1'b1;
            state    <= ST_DONE;
          end else begin
            cx         <= nx;
            cy         <= ny;
            vga_x      <= sum_x[7:0];
            vga_y      <= sum_y[6:0];
            vga_colour <= bc;
            vga_plot   <= pix_on;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
